// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
//   - STOP/NOSTOP stall-bit levels and the 6-bit stall vectors
//     (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB)
//   - mcause codes for external and timer machine interrupts
//   - mstatus bit indices (MIE, MPIE)
//   - trap/mret FSM state encoding
//   - helpers computing mstatus on trap entry and on mret
// Optional feature macro: PIPE_CTRL_TIMER_IRQ_EN (uses MCAUSE_TIMER).
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // A requesting stage and everything upstream of it stop; the stages
    // below keep moving so the next register downstream takes a bubble.
    localparam logic [5:0] STALL_NONE = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP};
    localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP,   STOP,   STOP};
    localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP,   STOP,   STOP,   STOP};
    localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP,   STOP,   STOP,   STOP,   STOP};
    // Trap sequence: hold PC and IF, feed bubbles into ID, let EX/MEM/WB drain.
    localparam logic [5:0] STALL_TRAP = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, STOP,   STOP};

    localparam logic [31:0] MCAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_IRQ_MEPC     = 3'd1;
    localparam logic [2:0] ST_IRQ_MCAUSE   = 3'd2;
    localparam logic [2:0] ST_IRQ_MSTATUS  = 3'd3;
    localparam logic [2:0] ST_IRQ_JUMP     = 3'd4;
    localparam logic [2:0] ST_MRET_MSTATUS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE         = ST_IDLE,
        S_IRQ_MEPC     = ST_IRQ_MEPC,
        S_IRQ_MCAUSE   = ST_IRQ_MCAUSE,
        S_IRQ_MSTATUS  = ST_IRQ_MSTATUS,
        S_IRQ_JUMP     = ST_IRQ_JUMP,
        S_MRET_MSTATUS = ST_MRET_MSTATUS
    } state_e;

    // Trap entry: MPIE <= MIE, MIE <= 0.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // mret: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_trap_fsm.sv
// pipe_ctrl_trap_fsm: interrupt entry / mret exit sequencer.
// Holds the FSM state, the saved epc/cause and the CSR write mux, and
// decides in IDLE whether a jump, an mret or an interrupt is taken.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_irq_pend, i_irq_cause pending interrupt and the cause it would get
//   i_stall_any, i_mem_stall any stall request / MEM bus-wait request
//   i_jump_req, i_mret      redirect requests from EX
//   i_id_valid, i_id_pc     ID holds a real instruction, and its PC
//   i_mstatus               current mstatus
//   o_state                 FSM state (also used by the top for muxing)
//   o_irq_take, o_jump_take, o_mret_take  same-cycle decisions
//   o_csr_we/waddr/wdata    CSR write port
module pipe_ctrl_trap_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_irq_pend,
    input  logic [31:0] i_irq_cause,
    input  logic        i_stall_any,
    input  logic        i_mem_stall,
    input  logic        i_jump_req,
    input  logic        i_mret,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_mstatus,
    output state_e      o_state,
    output logic        o_irq_take,
    output logic        o_jump_take,
    output logic        o_mret_take,
    output logic        o_csr_we,
    output logic [11:0] o_csr_waddr,
    output logic [31:0] o_csr_wdata
);

    state_e      r_state;
    logic [31:0] r_epc;
    logic [31:0] r_cause;
    logic        w_idle_free;

    // Redirects and interrupt acceptance only happen in IDLE with no stall.
    // An interrupt yields to a jump/mret in EX and waits for a real
    // instruction in ID so that mepc points at something that will re-run.
    assign w_idle_free = (r_state == S_IDLE) && !i_stall_any;
    assign o_jump_take = w_idle_free && i_jump_req;
    assign o_mret_take = w_idle_free && i_mret && !i_jump_req;
    assign o_irq_take  = w_idle_free && i_irq_pend && i_mstatus[MSTATUS_MIE]
                         && i_id_valid && !i_jump_req && !i_mret;
    assign o_state     = r_state;

    // A MEM bus wait freezes every IRQ_* state; the CSR write it drives
    // simply repeats, which is harmless.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_epc   <= 32'h0;
            r_cause <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (o_irq_take) begin
                        r_epc   <= i_id_pc;
                        r_cause <= i_irq_cause;
                        r_state <= S_IRQ_MEPC;
                    end else if (o_mret_take) begin
                        r_state <= S_MRET_MSTATUS;
                    end
                end
                S_IRQ_MEPC:     if (!i_mem_stall) r_state <= S_IRQ_MCAUSE;
                S_IRQ_MCAUSE:   if (!i_mem_stall) r_state <= S_IRQ_MSTATUS;
                S_IRQ_MSTATUS:  if (!i_mem_stall) r_state <= S_IRQ_JUMP;
                S_IRQ_JUMP:     if (!i_mem_stall) r_state <= S_IDLE;
                S_MRET_MSTATUS: r_state <= S_IDLE;
                default:        r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_csr_we    = 1'b0;
        o_csr_waddr = 12'h0;
        o_csr_wdata = 32'h0;
        case (r_state)
            S_IRQ_MEPC: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MEPC;
                o_csr_wdata = r_epc;
            end
            S_IRQ_MCAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MCAUSE;
                o_csr_wdata = r_cause;
            end
            S_IRQ_MSTATUS: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = trap_mstatus(i_mstatus);
            end
            S_MRET_MSTATUS: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = mret_mstatus(i_mstatus);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
// Merges stall requests (MEM > EX > ID) into the 6-bit stall vector,
// produces jump / interrupt flush pulses and redirects the PC for jumps,
// mret and trap entry. The trap/mret sequencing lives in pipe_ctrl_trap_fsm.
// Optional feature macro: PIPE_CTRL_TIMER_IRQ_EN adds timer_irq_in and
// mtie_in; the external interrupt wins over the timer in the accept cycle.
// Ports:
//   clk_in, reset_in                 clock, synchronous active-high reset
//   stallreq_{id,ex,mem}_in          per-stage stall requests
//   jump_req_in, jump_target_in      taken branch/jump from EX
//   mret_in                          mret decoded in EX
//   irq_in                           level external interrupt
//   id_pc_in, id_valid_in            instruction currently in ID
//   mstatus_in, mtvec_in, mepc_in    CSR values
//   stall_out                        bit0 PC .. bit5 WB, 1 = stop
//   jump_flush_out, interrupt_flush_out  flush IF/ID and ID/EX
//   new_pc_out, new_pc_valid_out     PC redirect
//   csr_we_out, csr_waddr_out, csr_wdata_out  CSR write port
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        stallreq_id_in,
    input  logic        stallreq_ex_in,
    input  logic        stallreq_mem_in,
    input  logic        jump_req_in,
    input  logic [31:0] jump_target_in,
    input  logic        mret_in,
    input  logic        irq_in,
    input  logic [31:0] id_pc_in,
    input  logic        id_valid_in,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
`ifdef PIPE_CTRL_TIMER_IRQ_EN
    input  logic        timer_irq_in,
    input  logic        mtie_in,
`endif
    output logic [5:0]  stall_out,
    output logic        jump_flush_out,
    output logic        interrupt_flush_out,
    output logic [31:0] new_pc_out,
    output logic        new_pc_valid_out,
    output logic        csr_we_out,
    output logic [11:0] csr_waddr_out,
    output logic [31:0] csr_wdata_out
);

    logic [5:0]  w_stall_merged;
    logic        w_stall_any;
    logic        w_irq_pend;
    logic [31:0] w_irq_cause;
    state_e      w_state;
    logic        w_irq_take;
    logic        w_jump_take;
    logic        w_mret_take;
    logic        w_in_trap;

`ifdef PIPE_CTRL_TIMER_IRQ_EN
    assign w_irq_pend  = irq_in || (timer_irq_in && mtie_in);
    assign w_irq_cause = irq_in ? MCAUSE_EXT : MCAUSE_TIMER;
`else
    assign w_irq_pend  = irq_in;
    assign w_irq_cause = MCAUSE_EXT;
`endif

    always_comb begin
        if (stallreq_mem_in)     w_stall_merged = STALL_MEM;
        else if (stallreq_ex_in) w_stall_merged = STALL_EX;
        else if (stallreq_id_in) w_stall_merged = STALL_ID;
        else                     w_stall_merged = STALL_NONE;
    end

    assign w_stall_any = stallreq_id_in || stallreq_ex_in || stallreq_mem_in;

    pipe_ctrl_trap_fsm #(
        .CSR_MSTATUS (CSR_MSTATUS),
        .CSR_MEPC    (CSR_MEPC),
        .CSR_MCAUSE  (CSR_MCAUSE)
    ) u_trap_fsm (
        .i_clk       (clk_in),
        .i_rst       (reset_in),
        .i_irq_pend  (w_irq_pend),
        .i_irq_cause (w_irq_cause),
        .i_stall_any (w_stall_any),
        .i_mem_stall (stallreq_mem_in),
        .i_jump_req  (jump_req_in),
        .i_mret      (mret_in),
        .i_id_valid  (id_valid_in),
        .i_id_pc     (id_pc_in),
        .i_mstatus   (mstatus_in),
        .o_state     (w_state),
        .o_irq_take  (w_irq_take),
        .o_jump_take (w_jump_take),
        .o_mret_take (w_mret_take),
        .o_csr_we    (csr_we_out),
        .o_csr_waddr (csr_waddr_out),
        .o_csr_wdata (csr_wdata_out)
    );

    assign w_in_trap = (w_state == S_IRQ_MEPC) || (w_state == S_IRQ_MCAUSE)
                       || (w_state == S_IRQ_MSTATUS) || (w_state == S_IRQ_JUMP);

    // Inside the trap sequence only a MEM wait matters (it freezes the FSM);
    // IRQ_JUMP releases the hold so the PC can load the vector.
    always_comb begin
        if (w_in_trap) begin
            if (stallreq_mem_in)           stall_out = STALL_MEM;
            else if (w_state == S_IRQ_JUMP) stall_out = STALL_NONE;
            else                           stall_out = STALL_TRAP;
        end else begin
            stall_out = w_stall_merged;
        end
    end

    always_comb begin
        new_pc_valid_out = 1'b0;
        new_pc_out       = RESET_PC;
        if (w_jump_take) begin
            new_pc_valid_out = 1'b1;
            new_pc_out       = jump_target_in;
        end else if (w_mret_take) begin
            new_pc_valid_out = 1'b1;
            new_pc_out       = mepc_in;
        end else if ((w_state == S_IRQ_JUMP) && !stallreq_mem_in) begin
            new_pc_valid_out = 1'b1;
            new_pc_out       = mtvec_in & ~32'h3;  // direct mode, base only
        end
    end

    assign jump_flush_out      = w_jump_take || w_mret_take;
    assign interrupt_flush_out = w_irq_take;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl (default build).
module tb_pipe_ctrl;

    logic        clk_in;
    logic        reset_in;
    logic        stallreq_id_in;
    logic        stallreq_ex_in;
    logic        stallreq_mem_in;
    logic        jump_req_in;
    logic [31:0] jump_target_in;
    logic        mret_in;
    logic        irq_in;
    logic [31:0] id_pc_in;
    logic        id_valid_in;
    logic [31:0] mstatus_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic [5:0]  stall_out;
    logic        jump_flush_out;
    logic        interrupt_flush_out;
    logic [31:0] new_pc_out;
    logic        new_pc_valid_out;
    logic        csr_we_out;
    logic [11:0] csr_waddr_out;
    logic [31:0] csr_wdata_out;

    int n_vec;
    int n_err;
    logic [43:0] exp_q[$];  // {csr addr, csr data} in expected write order

    pipe_ctrl dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .stallreq_id_in      (stallreq_id_in),
        .stallreq_ex_in      (stallreq_ex_in),
        .stallreq_mem_in     (stallreq_mem_in),
        .jump_req_in         (jump_req_in),
        .jump_target_in      (jump_target_in),
        .mret_in             (mret_in),
        .irq_in              (irq_in),
        .id_pc_in            (id_pc_in),
        .id_valid_in         (id_valid_in),
        .mstatus_in          (mstatus_in),
        .mtvec_in            (mtvec_in),
        .mepc_in             (mepc_in),
        .stall_out           (stall_out),
        .jump_flush_out      (jump_flush_out),
        .interrupt_flush_out (interrupt_flush_out),
        .new_pc_out          (new_pc_out),
        .new_pc_valid_out    (new_pc_valid_out),
        .csr_we_out          (csr_we_out),
        .csr_waddr_out       (csr_waddr_out),
        .csr_wdata_out       (csr_wdata_out)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_in);
    endtask

    task automatic idle_inputs();
        stallreq_id_in  = 1'b0;
        stallreq_ex_in  = 1'b0;
        stallreq_mem_in = 1'b0;
        jump_req_in     = 1'b0;
        jump_target_in  = 32'h0;
        mret_in         = 1'b0;
        irq_in          = 1'b0;
        id_pc_in        = 32'h0;
        id_valid_in     = 1'b0;
        mstatus_in      = 32'h0;
        mtvec_in        = 32'h200;
        mepc_in         = 32'h0;
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_csr(input string tag);
        logic [43:0] e;
        chk({tag, "_we"}, {31'h0, csr_we_out}, 32'h1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, {20'h0, csr_waddr_out}, {20'h0, e[43:32]});
            chk({tag, "_data"}, csr_wdata_out, e[31:0]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        reset_in = 1'b1;
        tick();
        tick();

        // reset state
        settle();
        chk("rst_stall", {26'h0, stall_out}, 32'h0);
        chk("rst_jflush", {31'h0, jump_flush_out}, 32'h0);
        chk("rst_iflush", {31'h0, interrupt_flush_out}, 32'h0);
        chk("rst_pc", new_pc_out, 32'h0);
        chk("rst_pcv", {31'h0, new_pc_valid_out}, 32'h0);
        chk("rst_we", {31'h0, csr_we_out}, 32'h0);
        chk("rst_waddr", {20'h0, csr_waddr_out}, 32'h0);
        chk("rst_wdata", csr_wdata_out, 32'h0);
        reset_in = 1'b0;
        tick();

        // stall priority
        stallreq_id_in = 1'b1; stallreq_ex_in = 1'b1;
        settle(); chk("stall_ex_id", {26'h0, stall_out}, 32'h0F);
        stallreq_mem_in = 1'b1;
        settle(); chk("stall_mem", {26'h0, stall_out}, 32'h1F);
        stallreq_mem_in = 1'b0; stallreq_ex_in = 1'b0;
        settle(); chk("stall_id", {26'h0, stall_out}, 32'h07);
        stallreq_id_in = 1'b0;
        settle(); chk("stall_none", {26'h0, stall_out}, 32'h00);
        tick();

        // jump, same cycle, one-cycle pulse
        jump_req_in = 1'b1; jump_target_in = 32'h100;
        settle();
        chk("jmp_flush", {31'h0, jump_flush_out}, 32'h1);
        chk("jmp_pcv", {31'h0, new_pc_valid_out}, 32'h1);
        chk("jmp_pc", new_pc_out, 32'h100);
        tick();
        jump_req_in = 1'b0;
        settle();
        chk("jmp_flush_end", {31'h0, jump_flush_out}, 32'h0);
        chk("jmp_pcv_end", {31'h0, new_pc_valid_out}, 32'h0);
        chk("jmp_pc_idle", new_pc_out, 32'h0);
        tick();

        // jump held off under stall
        jump_req_in = 1'b1; jump_target_in = 32'h180; stallreq_ex_in = 1'b1;
        settle();
        chk("jmp_stall_flush", {31'h0, jump_flush_out}, 32'h0);
        chk("jmp_stall_pcv", {31'h0, new_pc_valid_out}, 32'h0);
        tick();
        stallreq_ex_in = 1'b0;
        settle();
        chk("jmp_after_stall_pc", new_pc_out, 32'h180);
        chk("jmp_after_stall_flush", {31'h0, jump_flush_out}, 32'h1);
        tick();
        jump_req_in = 1'b0;

        // deferral: bubble in ID, then jump present, then MIE = 0
        irq_in = 1'b1; mstatus_in = 32'h8; id_pc_in = 32'h40; id_valid_in = 1'b0;
        settle(); chk("defer_bubble", {31'h0, interrupt_flush_out}, 32'h0);
        tick();
        id_valid_in = 1'b1; jump_req_in = 1'b1; jump_target_in = 32'h300;
        settle();
        chk("defer_jump_iflush", {31'h0, interrupt_flush_out}, 32'h0);
        chk("defer_jump_jflush", {31'h0, jump_flush_out}, 32'h1);
        tick();
        jump_req_in = 1'b0; mstatus_in = 32'h0;
        settle(); chk("defer_mie0", {31'h0, interrupt_flush_out}, 32'h0);
        tick();
        settle();
        chk("defer_mie0_again", {31'h0, interrupt_flush_out}, 32'h0);
        chk("defer_mie0_we", {31'h0, csr_we_out}, 32'h0);
        tick();

        // interrupt entry
        mstatus_in = 32'h8; mtvec_in = 32'h200;
        exp_q.push_back({12'h341, 32'h40});
        exp_q.push_back({12'h342, 32'h8000000B});
        exp_q.push_back({12'h300, 32'h80});
        settle();
        chk("irq_accept", {31'h0, interrupt_flush_out}, 32'h1);
        chk("irq_accept_pcv", {31'h0, new_pc_valid_out}, 32'h0);
        tick();
        irq_in = 1'b0; id_valid_in = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            settle();
            chk("irq_trap_stall", {26'h0, stall_out}, 32'h03);
            chk("irq_trap_pcv", {31'h0, new_pc_valid_out}, 32'h0);
            chk_csr("irq_csr");
            tick();
        end
        settle();
        chk("irq_vec_pcv", {31'h0, new_pc_valid_out}, 32'h1);
        chk("irq_vec_pc", new_pc_out, 32'h200);
        chk("irq_vec_stall", {26'h0, stall_out}, 32'h0);
        chk("irq_vec_we", {31'h0, csr_we_out}, 32'h0);
        tick();
        settle();
        chk("irq_done_pcv", {31'h0, new_pc_valid_out}, 32'h0);
        tick();

        // MEM stall frozen in IRQ_MCAUSE for 3 cycles
        irq_in = 1'b1; id_valid_in = 1'b1; id_pc_in = 32'h40; mstatus_in = 32'h8;
        exp_q.push_back({12'h341, 32'h40});
        for (int k = 0; k < 4; k++) exp_q.push_back({12'h342, 32'h8000000B});
        exp_q.push_back({12'h300, 32'h80});
        settle(); chk("mst_accept", {31'h0, interrupt_flush_out}, 32'h1);
        tick();
        irq_in = 1'b0; id_valid_in = 1'b0;
        settle(); chk_csr("mst_mepc");
        tick();
        stallreq_mem_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("mst_stall", {26'h0, stall_out}, 32'h1F);
            chk_csr("mst_hold");
            tick();
        end
        stallreq_mem_in = 1'b0;
        settle();
        chk("mst_release_stall", {26'h0, stall_out}, 32'h03);
        chk_csr("mst_mcause");
        tick();
        settle(); chk_csr("mst_mstatus");
        tick();
        settle();
        chk("mst_vec_pcv", {31'h0, new_pc_valid_out}, 32'h1);
        chk("mst_vec_pc", new_pc_out, 32'h200);
        tick();

        // mret: redirect now, mstatus write next cycle, no accept there
        mret_in = 1'b1; mepc_in = 32'h44; mstatus_in = 32'h80;
        settle();
        chk("mret_pc", new_pc_out, 32'h44);
        chk("mret_pcv", {31'h0, new_pc_valid_out}, 32'h1);
        chk("mret_flush", {31'h0, jump_flush_out}, 32'h1);
        chk("mret_we_now", {31'h0, csr_we_out}, 32'h0);
        tick();
        mret_in = 1'b0; irq_in = 1'b1; id_valid_in = 1'b1; id_pc_in = 32'h48;
        mstatus_in = 32'h88;
        exp_q.push_back({12'h300, 32'h88});
        settle();
        chk_csr("mret_mstatus");
        chk("mret_no_accept", {31'h0, interrupt_flush_out}, 32'h0);
        chk("mret_pcv_end", {31'h0, new_pc_valid_out}, 32'h0);
        tick();
        settle(); chk("post_mret_accept", {31'h0, interrupt_flush_out}, 32'h1);
        tick();
        irq_in = 1'b0; id_valid_in = 1'b0;
        settle(); chk("midtrap_we", {31'h0, csr_we_out}, 32'h1);

        // reset mid-trap
        reset_in = 1'b1;
        tick();
        settle();
        chk("midrst_stall", {26'h0, stall_out}, 32'h0);
        chk("midrst_we", {31'h0, csr_we_out}, 32'h0);
        chk("midrst_waddr", {20'h0, csr_waddr_out}, 32'h0);
        chk("midrst_wdata", csr_wdata_out, 32'h0);
        chk("midrst_pcv", {31'h0, new_pc_valid_out}, 32'h0);
        chk("midrst_pc", new_pc_out, 32'h0);
        reset_in = 1'b0;
        tick();
        settle();
        chk("postrst_we", {31'h0, csr_we_out}, 32'h0);
        chk("postrst_stall", {26'h0, stall_out}, 32'h0);

        chk("exp_q_drained", exp_q.size(), 32'h0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the 6-bit stall vector consumed by all pipeline registers.
- Generates jump and interrupt flush pulses.
- Sequences machine-interrupt entry and mret exit with a small FSM that writes mepc/mcause/mstatus over the CSR write port and redirects the PC.

Parameters:
- RESET_PC, 32'h0, PC value presented on new_pc_out while idle.
- CSR_MSTATUS, 12'h300, mstatus address.
- CSR_MEPC, 12'h341, mepc address.
- CSR_MCAUSE, 12'h342, mcause address.

Ports:
- clk_in  in  1  core clock
- reset_in  in  1  synchronous reset, active-high
- stallreq_id_in  in  1  load-use hazard from ID
- stallreq_ex_in  in  1  multi-cycle op busy in EX
- stallreq_mem_in  in  1  bus wait in MEM
- jump_req_in  in  1  taken branch/jump resolved in EX
- jump_target_in  in  32  jump destination
- mret_in  in  1  mret decoded in EX
- irq_in  in  1  external interrupt, level
- id_pc_in  in  32  PC of instruction in ID
- id_valid_in  in  1  ID holds a real (non-bubble) instruction
- mstatus_in  in  32  current mstatus
- mtvec_in  in  32  trap vector
- mepc_in  in  32  current mepc
- stall_out  out  6  bit0 PC … bit5 WB; 1 = STOP
- jump_flush_out  out  1  flush IF/ID and ID/EX
- interrupt_flush_out  out  1  flush IF/ID and ID/EX for trap entry
- new_pc_out  out  32  redirect target
- new_pc_valid_out  out  1  PC loads new_pc_out this cycle
- csr_we_out  out  1  CSR write enable
- csr_waddr_out  out  12  CSR write address
- csr_wdata_out  out  32  CSR write data

Behaviour:
- Reset: FSM to IDLE. All outputs 0, except new_pc_out = RESET_PC. Saved registers (epc_q, cause_q) cleared. A reset mid-sequence abandons the sequence; the level irq is simply retaken later.
- Stall vector (combinational, priority MEM > EX > ID):
  - mem request → 6'b011111
  - ex request → 6'b001111
  - id request → 6'b000111
  - none → 6'b000000
  - Bits above the requesting stage stay 0, so the downstream register receives a bubble.
- Jump (IDLE only, no stall): jump_flush_out = 1, new_pc_valid_out = 1, new_pc_out = jump_target_in, same cycle (0 latency). When a stall is active, the jump is held off until the stall clears; EX holds the jump request under stall.
- FSM states: IDLE, IRQ_MEPC, IRQ_MCAUSE, IRQ_MSTATUS, IRQ_JUMP, MRET_MSTATUS.
- Interrupt accept, IDLE → IRQ_MEPC. All of the following must hold:
  - irq_in & mstatus_in[3] (MIE)
  - id_valid_in
  - no stall request
  - no jump_req_in, no mret_in
- Interrupt accept cycle:
  - interrupt_flush_out = 1
  - epc_q <= id_pc_in
  - cause_q <= 32'h8000000B
- Deferral: if ID holds a bubble or a jump/mret is present, acceptance is deferred; irq stays pending (level).
- Trap sequence, one cycle each, stall_out = 6'b000011 throughout (PC and IF held, IF/ID bubbles), older instructions in EX/MEM/WB drain:
  - IRQ_MEPC: csr write CSR_MEPC ← epc_q.
  - IRQ_MCAUSE: csr write CSR_MCAUSE ← cause_q.
  - IRQ_MSTATUS: csr write CSR_MSTATUS ← mstatus_in with bit7 (MPIE) = bit3 and bit3 (MIE) = 0.
  - IRQ_JUMP: new_pc_valid_out = 1, new_pc_out = {mtvec_in[31:2], 2'b00}, stall released, → IDLE.
- Stall during the sequence: stallreq_mem_in asserted during any IRQ_* state freezes the FSM in that state with stall_out = 6'b011111. The CSR write repeats (idempotent).
- mret (IDLE, no stall), same cycle:
  - jump_flush_out = 1
  - new_pc_valid_out = 1, new_pc_out = mepc_in
  - → MRET_MSTATUS
- MRET_MSTATUS: write mstatus with MIE = MPIE and MPIE = 1; → IDLE. No interrupt is accepted in this cycle.
- Latency:
  - Interrupt accept to handler fetch: 4 cycles.
  - mret: 0 cycles for the redirect, plus 1 cycle for the CSR write.

Optional Feature:
PIPE_CTRL_TIMER_IRQ_EN
- Defined: adds port timer_irq_in (in, 1) and gates acceptance with mie bit7 via an extra port mtie_in.
- Priority: external (cause 32'h8000000B) over timer (cause 32'h80000007), resolved in the accept cycle.
- Undefined: neither port exists; only external interrupts are taken.

Decomposition:
- Shared defines file holds:
  - STOP/NOSTOP
  - stall vector constants (STALL_NONE/ID/EX/MEM/TRAP)
  - mcause codes
  - mstatus bit indices (MIE=3, MPIE=7)
  - FSM state encoding (3-bit localparams)
- The stall merge is kept inline.
- One sub-module is natural: pipe_ctrl_trap_fsm, holding the FSM, epc_q/cause_q and the CSR write mux. pipe_ctrl instantiates it and muxes its stall/PC outputs.

Test Plan:
- Stall priority: stallreq_ex_in = 1 with stallreq_id_in = 1 → stall_out = 6'b001111. Add stallreq_mem_in → 6'b011111. Release all → 6'b000000.
- Jump: jump_req_in = 1, target 32'h0000_0100 → same-cycle jump_flush_out = 1, new_pc_valid_out = 1, new_pc_out = 32'h100. The pulse lasts exactly 1 cycle.
- Interrupt entry, inputs:
  - irq_in = 1, mstatus_in = 32'h8
  - id_pc_in = 32'h40, id_valid_in = 1
  - mtvec_in = 32'h200
- Interrupt entry, required response:
  - interrupt_flush_out pulses.
  - CSR writes in order: 341←32'h40, 342←32'h8000000B, 300←32'h80.
  - new_pc_out = 32'h200 valid on the 4th cycle after accept.
- Deferral: irq_in with id_valid_in = 0, or with a simultaneous jump_req_in → no accept until the next eligible cycle. mstatus MIE = 0 → never accepted.
- Mem stall inside trap: stallreq_mem_in held for 3 cycles in IRQ_MCAUSE → the state and the mcause write persist for those cycles, and the sequence then completes.
- mret then reset: mret_in with mepc_in = 32'h44 and mstatus_in = 32'h80 → new_pc_out = 32'h44; next cycle mstatus ← 32'h88. reset_in mid-trap → IDLE, all outputs 0.
